// File: rtl/mem_store_seq_checker.sv
// Bus-sequence checker for N-byte SM83 stores: follows the immediate fetch, each write M-cycle and the next opcode fetch.
// Optional MSC_INTERNAL_MCYC_EN adds INTERNAL_MCYC idle M-cycles between the immediates and the first write.
module mem_store_seq_checker #(
  parameter int NBYTES    = 2,
  parameter int IMM_BYTES = 2,
  parameter int ADDR_DEC  = 0
`ifdef MSC_INTERNAL_MCYC_EN
  , parameter int INTERNAL_MCYC = 1
`endif
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  mcyc_end,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [15:0]           adr,
  input  logic [7:0]            din,
  input  logic [7:0]            dout,
  input  logic [15:0]           pc,
  input  logic [15:0]           base_in,
  input  logic [8*NBYTES-1:0]   value,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            err_code,
  output logic [15:0]           base_addr,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_IMM         = 3'd1,
    S_INTERNAL    = 3'd2,
    S_STORE       = 3'd3,
    S_CHECK_FETCH = 3'd4,
    S_ERR         = 3'd5
  } state_t;

`ifdef MSC_INTERNAL_MCYC_EN
  localparam state_t AFTER_IMM = (INTERNAL_MCYC > 0) ? S_INTERNAL : S_STORE;
`else
  localparam state_t AFTER_IMM = S_STORE;
`endif
  localparam state_t FIRST_STATE = (IMM_BYTES > 0) ? S_IMM : AFTER_IMM;

  state_t      state;
  logic [1:0]  k;
  logic        imm_idx;
  logic [7:0]  imm_lo;
`ifdef MSC_INTERNAL_MCYC_EN
  logic [7:0]  int_cnt;
  logic [15:0] pc_ref;
`endif

  logic [1:0]  byte_idx;
  logic [15:0] exp_adr;
  logic [7:0]  exp_data;
  logic        last_k;
  logic        last_imm;
  logic [15:0] imm_base;
  logic [2:0]  chk_code;

  assign state_dbg = state;

  // Push order walks the address down and the value bytes from the top.
  assign byte_idx = (ADDR_DEC != 0) ? (2'(NBYTES - 1) - k) : k;
  assign exp_adr  = (ADDR_DEC != 0) ? (base_addr - 16'd1 - {14'd0, k})
                                    : (base_addr + {14'd0, k});
  assign exp_data = 8'(value >> {byte_idx, 3'b000});
  assign last_k   = (k == 2'(NBYTES - 1));
  assign last_imm = (imm_idx == 1'(IMM_BYTES - 1));
  assign imm_base = (IMM_BYTES == 1) ? {8'hFF, din} : {din, imm_lo};

  // Error cause for the current M-cycle; only acted on when mcyc_end is high.
  always_comb begin
    chk_code = 3'd0;
    case (state)
      S_IMM: begin
        if (!rd || wr)       chk_code = 3'd1;
        else if (adr != pc)  chk_code = 3'd2;
      end
`ifdef MSC_INTERNAL_MCYC_EN
      S_INTERNAL: begin
        if (rd || wr || ((int_cnt != 8'd0) && (pc != pc_ref))) chk_code = 3'd3;
      end
`endif
      S_STORE: begin
        if (!wr || rd)              chk_code = 3'd3;
        else if (adr != exp_adr)    chk_code = 3'd4;
        else if (dout != exp_data)  chk_code = 3'd5;
      end
      S_CHECK_FETCH: begin
        if (!rd || wr || (adr != pc)) chk_code = 3'd6;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 3'd0;
      base_addr <= 16'd0;
      k         <= 2'd0;
      imm_idx   <= 1'b0;
      imm_lo    <= 8'd0;
`ifdef MSC_INTERNAL_MCYC_EN
      int_cnt   <= 8'd0;
      pc_ref    <= 16'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          // start wins over a coincident mcyc_end, which belongs to the M1 fetch
          if (start) begin
            state    <= FIRST_STATE;
            busy     <= 1'b1;
            err      <= 1'b0;
            err_code <= 3'd0;
            k        <= 2'd0;
            imm_idx  <= 1'b0;
`ifdef MSC_INTERNAL_MCYC_EN
            int_cnt  <= 8'd0;
`endif
            if (IMM_BYTES == 0) base_addr <= base_in;
          end
        end
        default: begin
          if (start) begin
            state    <= S_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= 3'd7;
          end else if (mcyc_end) begin
            if (chk_code != 3'd0) begin
              state    <= S_ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= chk_code;
            end else begin
              case (state)
                S_IMM: begin
                  imm_lo  <= din;
                  imm_idx <= imm_idx + 1'b1;
                  if (last_imm) begin
                    base_addr <= imm_base;
                    state     <= AFTER_IMM;
                  end
                end
`ifdef MSC_INTERNAL_MCYC_EN
                S_INTERNAL: begin
                  if (int_cnt == 8'd0) pc_ref <= pc;
                  int_cnt <= int_cnt + 8'd1;
                  if (int_cnt == 8'(INTERNAL_MCYC - 1)) state <= S_STORE;
                end
`endif
                S_STORE: begin
                  k <= k + 2'd1;
                  if (last_k) state <= S_CHECK_FETCH;
                end
                S_CHECK_FETCH: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_seq_checker.sv
// Directed bench for mem_store_seq_checker: three instances (LD (nn),SP / LDH (n),A / PUSH) driven from one vector table.
module tb_mem_store_seq_checker;

  localparam int K_START = 0;
  localparam int K_MC    = 1;
  localparam int K_IDLE  = 2;

  typedef struct {
    int          inst;
    int          kind;
    logic        rd;
    logic        wr;
    logic [15:0] adr;
    logic [7:0]  dat;
    logic [15:0] pc;
    logic [15:0] val;
    logic [21:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [2:0]  starts = 3'd0;
  logic        mcyc_end = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [15:0] adr = 16'd0, pc = 16'd0, base_in = 16'd0;
  logic [7:0]  din = 8'd0, dout = 8'd0;
  logic [15:0] value = 16'd0;

  logic [2:0]  busy_v, done_v, err_v;
  logic [2:0]  code_v [3];
  logic [15:0] base_v [3];
  logic [2:0]  state_v [3];
  logic [21:0] obs [3];

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  mem_store_seq_checker u_def (
    .clk(clk), .nreset(nreset), .start(starts[0]), .mcyc_end(mcyc_end),
    .rd(rd), .wr(wr), .adr(adr), .din(din), .dout(dout), .pc(pc),
    .base_in(base_in), .value(value),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .err_code(code_v[0]),
    .base_addr(base_v[0]), .state_dbg(state_v[0])
  );

  mem_store_seq_checker #(.NBYTES(1), .IMM_BYTES(1)) u_ldh (
    .clk(clk), .nreset(nreset), .start(starts[1]), .mcyc_end(mcyc_end),
    .rd(rd), .wr(wr), .adr(adr), .din(din), .dout(dout), .pc(pc),
    .base_in(base_in), .value(value[7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .err_code(code_v[1]),
    .base_addr(base_v[1]), .state_dbg(state_v[1])
  );

  mem_store_seq_checker #(.IMM_BYTES(0), .ADDR_DEC(1)) u_push (
    .clk(clk), .nreset(nreset), .start(starts[2]), .mcyc_end(mcyc_end),
    .rd(rd), .wr(wr), .adr(adr), .din(din), .dout(dout), .pc(pc),
    .base_in(base_in), .value(value),
    .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .err_code(code_v[2]),
    .base_addr(base_v[2]), .state_dbg(state_v[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {busy_v[g], done_v[g], err_v[g], code_v[g], base_v[g]};
  end

  // Expected-output encoders: {busy, done, err, err_code, base_addr}
  function automatic logic [21:0] run(input logic [15:0] b);
    return {3'b100, 3'd0, b};
  endfunction
  function automatic logic [21:0] fin(input logic [15:0] b);
    return {3'b010, 3'd0, b};
  endfunction
  function automatic logic [21:0] er(input logic [2:0] c, input logic [15:0] b);
    return {3'b001, c, b};
  endfunction
  function automatic logic [21:0] idl(input logic [15:0] b);
    return {3'b000, 3'd0, b};
  endfunction

  function automatic vec_t mk(input int inst, input int kind, input logic r, input logic w,
                              input logic [15:0] a, input logic [7:0] d, input logic [15:0] p,
                              input logic [15:0] v, input logic [21:0] e);
    vec_t t;
    t.inst = inst; t.kind = kind; t.rd = r; t.wr = w; t.adr = a;
    t.dat = d; t.pc = p; t.val = v; t.exp = e;
    return t;
  endfunction
  function automatic vec_t st(input int i, input logic [15:0] v, input logic [15:0] b, input logic [21:0] e);
    return mk(i, K_START, 1'b0, 1'b0, b, 8'd0, 16'd0, v, e);
  endfunction
  function automatic vec_t rc(input int i, input logic [15:0] a, input logic [7:0] d, input logic [15:0] p, input logic [21:0] e);
    return mk(i, K_MC, 1'b1, 1'b0, a, d, p, 16'd0, e);
  endfunction
  function automatic vec_t wc(input int i, input logic [15:0] a, input logic [7:0] d, input logic [15:0] p, input logic [21:0] e);
    return mk(i, K_MC, 1'b0, 1'b1, a, d, p, 16'd0, e);
  endfunction
  function automatic vec_t mc(input int i, input logic r, input logic w, input logic [15:0] a, input logic [15:0] p, input logic [21:0] e);
    return mk(i, K_MC, r, w, a, 8'd0, p, 16'd0, e);
  endfunction
  function automatic vec_t ic(input int i, input logic [21:0] e);
    return mk(i, K_IDLE, 1'b0, 1'b0, 16'd0, 8'd0, 16'd0, 16'd0, e);
  endfunction

  task automatic check(input string name, input int inst, input logic [21:0] got, input logic [21:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s inst%0d: got busy/done/err/code/base=%b/%b/%b/%0d/%h, want %b/%b/%b/%0d/%h",
               name, inst, got[21], got[20], got[19], got[18:16], got[15:0],
               want[21], want[20], want[19], want[18:16], want[15:0]);
    end
  endtask

  // One record: an optional don't-care T-cycle, then the start pulse or the mcyc_end cycle.
  task automatic run_vec(input vec_t r, input int idx);
    logic [21:0] e;
    @(negedge clk);
    if (r.kind == K_MC) begin
      rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      adr = 16'($urandom); pc = 16'($urandom);
      din = 8'($urandom); dout = 8'($urandom);
      @(negedge clk);
    end
    case (r.kind)
      K_START: begin value = r.val; base_in = r.adr; starts[r.inst] = 1'b1; end
      K_MC:    begin mcyc_end = 1'b1; rd = r.rd; wr = r.wr; adr = r.adr;
                     din = r.dat; dout = r.dat; pc = r.pc; end
      default: ;
    endcase
    @(negedge clk);
    starts = 3'd0;
    mcyc_end = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("vec%0d", idx), r.inst, obs[r.inst], e);
  endtask

  task automatic run_one(input vec_t r, input int idx);
    exp_q.push_back(r.exp);
    run_vec(r, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // LD (nn),SP at C123
    vecs.push_back(st(0, 16'hBEEF, 16'h0000, run(16'h0000)));
    vecs.push_back(rc(0, 16'h0101, 8'h23, 16'h0101, run(16'h0000)));
    vecs.push_back(rc(0, 16'h0102, 8'hC1, 16'h0102, run(16'hC123)));
    vecs.push_back(wc(0, 16'hC123, 8'hEF, 16'h0103, run(16'hC123)));
    vecs.push_back(wc(0, 16'hC124, 8'hBE, 16'h0103, run(16'hC123)));
    vecs.push_back(rc(0, 16'h0103, 8'h00, 16'h0103, fin(16'hC123)));
    vecs.push_back(ic(0, idl(16'hC123)));
    // address wrap FFFF -> 0000
    vecs.push_back(st(0, 16'h1234, 16'h0000, run(16'hC123)));
    vecs.push_back(rc(0, 16'h0201, 8'hFF, 16'h0201, run(16'hC123)));
    vecs.push_back(rc(0, 16'h0202, 8'hFF, 16'h0202, run(16'hFFFF)));
    vecs.push_back(wc(0, 16'hFFFF, 8'h34, 16'h0203, run(16'hFFFF)));
    vecs.push_back(wc(0, 16'h0000, 8'h12, 16'h0203, run(16'hFFFF)));
    vecs.push_back(rc(0, 16'h0203, 8'h00, 16'h0203, fin(16'hFFFF)));
    // data mismatch on second write; error holds, no done
    vecs.push_back(st(0, 16'hBEEF, 16'h0000, run(16'hFFFF)));
    vecs.push_back(rc(0, 16'h0301, 8'h23, 16'h0301, run(16'hFFFF)));
    vecs.push_back(rc(0, 16'h0302, 8'hC1, 16'h0302, run(16'hC123)));
    vecs.push_back(wc(0, 16'hC123, 8'hEF, 16'h0303, run(16'hC123)));
    vecs.push_back(wc(0, 16'hC124, 8'hBF, 16'h0303, er(3'd5, 16'hC123)));
    vecs.push_back(rc(0, 16'h0303, 8'h00, 16'h0303, er(3'd5, 16'hC123)));
    // IMM not a read
    vecs.push_back(st(0, 16'hBEEF, 16'h0000, run(16'hC123)));
    vecs.push_back(mc(0, 1'b0, 1'b1, 16'h0401, 16'h0401, er(3'd1, 16'hC123)));
    // IMM address != pc
    vecs.push_back(st(0, 16'hBEEF, 16'h0000, run(16'hC123)));
    vecs.push_back(rc(0, 16'h0401, 8'h00, 16'h0402, er(3'd2, 16'hC123)));
    // STORE with both strobes
    vecs.push_back(st(0, 16'hBEEF, 16'h0000, run(16'hC123)));
    vecs.push_back(rc(0, 16'h0501, 8'h34, 16'h0501, run(16'hC123)));
    vecs.push_back(rc(0, 16'h0502, 8'h12, 16'h0502, run(16'h1234)));
    vecs.push_back(mc(0, 1'b1, 1'b1, 16'h1234, 16'h0503, er(3'd3, 16'h1234)));
    // STORE address mismatch
    vecs.push_back(st(0, 16'hBEEF, 16'h0000, run(16'h1234)));
    vecs.push_back(rc(0, 16'h0601, 8'h00, 16'h0601, run(16'h1234)));
    vecs.push_back(rc(0, 16'h0602, 8'h80, 16'h0602, run(16'h8000)));
    vecs.push_back(wc(0, 16'h8001, 8'hEF, 16'h0603, er(3'd4, 16'h8000)));
    // fetch mismatch after good writes
    vecs.push_back(st(0, 16'h00FF, 16'h0000, run(16'h8000)));
    vecs.push_back(rc(0, 16'h0701, 8'hFE, 16'h0701, run(16'h8000)));
    vecs.push_back(rc(0, 16'h0702, 8'hFF, 16'h0702, run(16'hFFFE)));
    vecs.push_back(wc(0, 16'hFFFE, 8'hFF, 16'h0703, run(16'hFFFE)));
    vecs.push_back(wc(0, 16'hFFFF, 8'h00, 16'h0703, run(16'hFFFE)));
    vecs.push_back(rc(0, 16'h0704, 8'h00, 16'h0703, er(3'd6, 16'hFFFE)));
    // start while busy
    vecs.push_back(st(0, 16'hBEEF, 16'h0000, run(16'hFFFE)));
    vecs.push_back(rc(0, 16'h0801, 8'h10, 16'h0801, run(16'hFFFE)));
    vecs.push_back(st(0, 16'hBEEF, 16'h0000, er(3'd7, 16'hFFFE)));
    vecs.push_back(rc(0, 16'h0802, 8'h20, 16'h0802, er(3'd7, 16'hFFFE)));
    // recovery from ERR
    vecs.push_back(st(0, 16'h5678, 16'h0000, run(16'hFFFE)));
    vecs.push_back(rc(0, 16'h0901, 8'h00, 16'h0901, run(16'hFFFE)));
    vecs.push_back(rc(0, 16'h0902, 8'h90, 16'h0902, run(16'h9000)));
    vecs.push_back(wc(0, 16'h9000, 8'h78, 16'h0903, run(16'h9000)));
    vecs.push_back(wc(0, 16'h9001, 8'h56, 16'h0903, run(16'h9000)));
    vecs.push_back(rc(0, 16'h0903, 8'h00, 16'h0903, fin(16'h9000)));
    // LDH (n),A
    vecs.push_back(st(1, 16'h005A, 16'h0000, run(16'h0000)));
    vecs.push_back(rc(1, 16'h0101, 8'h80, 16'h0101, run(16'hFF80)));
    vecs.push_back(wc(1, 16'hFF80, 8'h5A, 16'h0102, run(16'hFF80)));
    vecs.push_back(rc(1, 16'h0102, 8'h00, 16'h0102, fin(16'hFF80)));
    vecs.push_back(ic(1, idl(16'hFF80)));
    vecs.push_back(st(1, 16'h005A, 16'h0000, run(16'hFF80)));
    vecs.push_back(rc(1, 16'h0201, 8'h81, 16'h0201, run(16'hFF81)));
    vecs.push_back(wc(1, 16'hFF80, 8'h5A, 16'h0202, er(3'd4, 16'hFF81)));
    // PUSH BC
    vecs.push_back(st(2, 16'hABCD, 16'hDFFE, run(16'hDFFE)));
`ifdef MSC_INTERNAL_MCYC_EN
    vecs.push_back(mc(2, 1'b0, 1'b0, 16'hDFFE, 16'h0101, run(16'hDFFE)));
`endif
    vecs.push_back(wc(2, 16'hDFFD, 8'hAB, 16'h0101, run(16'hDFFE)));
    vecs.push_back(wc(2, 16'hDFFC, 8'hCD, 16'h0101, run(16'hDFFE)));
    vecs.push_back(rc(2, 16'h0101, 8'h00, 16'h0101, fin(16'hDFFE)));
`ifdef MSC_INTERNAL_MCYC_EN
    vecs.push_back(st(2, 16'hABCD, 16'hDFFE, run(16'hDFFE)));
    vecs.push_back(mc(2, 1'b1, 1'b0, 16'hDFFE, 16'h0201, er(3'd3, 16'hDFFE)));
`endif
    vecs.push_back(st(2, 16'hABCD, 16'hC000, run(16'hC000)));
`ifdef MSC_INTERNAL_MCYC_EN
    vecs.push_back(mc(2, 1'b0, 1'b0, 16'hC000, 16'h0301, run(16'hC000)));
`endif
    vecs.push_back(wc(2, 16'hBFFF, 8'hCD, 16'h0301, er(3'd5, 16'hC000)));

    foreach (vecs[i]) exp_q.push_back(vecs[i].exp);

    // reset state, during and after reset
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_hold", i, obs[i], idl(16'h0000));
      tests++;
      if (state_v[i] !== 3'd0) begin
        fails++;
        $display("FAIL reset_state inst%0d: got %0d, want 0", i, state_v[i]);
      end
    end
    nreset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check("reset_release", i, obs[i], idl(16'h0000));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // start and mcyc_end together in IDLE: that mcyc_end (bad strobes) is not evaluated
    @(negedge clk);
    value = 16'hBEEF; starts[0] = 1'b1; mcyc_end = 1'b1;
    rd = 1'b1; wr = 1'b1; adr = 16'h1111; pc = 16'h2222;
    @(negedge clk);
    starts = 3'd0; mcyc_end = 1'b0;
    check("start_mcyc_same", 0, obs[0], run(16'h9000));
    run_one(rc(0, 16'h0A01, 8'h23, 16'h0A01, run(16'h9000)), 100);
    run_one(rc(0, 16'h0A02, 8'hC1, 16'h0A02, run(16'hC123)), 101);
    run_one(wc(0, 16'hC123, 8'hEF, 16'h0A03, run(16'hC123)), 102);
    run_one(wc(0, 16'hC124, 8'hBE, 16'h0A03, run(16'hC123)), 103);
    run_one(rc(0, 16'h0A03, 8'h00, 16'h0A03, fin(16'hC123)), 104);

    // reset during STORE k=1: asynchronous clear, then no done from the rest of the bus traffic
    run_one(st(0, 16'hBEEF, 16'h0000, run(16'hC123)), 110);
    run_one(rc(0, 16'h0B01, 8'h23, 16'h0B01, run(16'hC123)), 111);
    run_one(rc(0, 16'h0B02, 8'hC1, 16'h0B02, run(16'hC123)), 112);
    run_one(wc(0, 16'hC123, 8'hEF, 16'h0B03, run(16'hC123)), 113);
    @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    check("reset_async", 0, obs[0], idl(16'h0000));
    @(negedge clk);
    nreset = 1'b1;
    run_one(wc(0, 16'hC124, 8'hBE, 16'h0B03, idl(16'h0000)), 114);
    run_one(rc(0, 16'h0B03, 8'h00, 16'h0B03, idl(16'h0000)), 115);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
